// File: rtl/cache_pkg.sv
// Shared types for the set-associative write-back data cache.
// FLUSH_SCAN only exists when CACHE_FLUSH_EN is defined.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB        = 3'd1,
        FILL_REQ  = 3'd2,
        FILL_WAIT = 3'd3
`ifdef CACHE_FLUSH_EN
        ,
        FLUSH_SCAN = 3'd4
`endif
    } cache_state_e;

    // Way-number width; a direct-mapped build still needs one bit.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim pick for one set: lowest invalid way, else the round-robin
// pointer of that set; also owns the per-set pointers.
module cache_victim_sel #(
    parameter int INDEX_BITS = 2,
    parameter int WAYS       = 2,
    parameter int WAY_W      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] set_idx,
    input  logic [WAYS-1:0]       valid_vec,
    input  logic                  advance,
    output logic [WAY_W-1:0]      victim_way,
    output logic                  by_ptr
);

    localparam int SETS = 2 ** INDEX_BITS;

    logic [WAY_W-1:0] ptr [SETS];
    logic [WAY_W-1:0] first_inv;

    always_comb begin
        first_inv = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) first_inv = WAY_W'(w);
        end
    end

    assign by_ptr     = &valid_vec;
    assign victim_way = by_ptr ? ptr[set_idx] : first_inv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) ptr[s] <= '0;
        end else if (advance) begin
            ptr[set_idx] <= (WAYS == 1) ? '0 : ptr[set_idx] + 1'b1;
        end
    end

endmodule

// File: rtl/ram_cache_assoc.sv
// N-way set-associative write-back, write-allocate cache in front of RAM port A.
// Define CACHE_FLUSH_EN to add the flush/flush_done dirty-line write-back engine.
module ram_cache_assoc
    import cache_pkg::*;
#(
    parameter int  DATA_WIDTH         = 16,
    parameter int  RAM_REGISTER_COUNT = 1024,
    parameter int  INDEX_BITS         = 2,
    parameter int  WAYS               = 2,
    localparam int ADDR_W             = $clog2(RAM_REGISTER_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cpu_data_addr,
    input  logic                  cpu_read_m,
    input  logic                  cpu_write_m,
    input  logic [DATA_WIDTH-1:0] cpu_out_m,
    output logic [DATA_WIDTH-1:0] cpu_in_m,
    output logic                  cpu_stall,
    input  logic [DATA_WIDTH-1:0] ram_in_m,
    output logic [DATA_WIDTH-1:0] ram_out_m,
    output logic                  ram_write_m,
    output logic [ADDR_W-1:0]     ram_data_addr
`ifdef CACHE_FLUSH_EN
    ,
    input  logic                  flush,
    output logic                  flush_done
`endif
);

    localparam int SETS  = 2 ** INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS;
    localparam int WAY_W = way_bits(WAYS);

    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [TAG_W-1:0]      tag;
        logic [DATA_WIDTH-1:0] data;
    } cache_line_t;

    cache_line_t lines [SETS][WAYS];
    cache_state_e state;

    logic [WAY_W-1:0] vic_way_q;
    logic             vic_ptr_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  req;
    logic                  hit;
    logic                  miss;
    logic [WAY_W-1:0]      hit_way;
    logic [WAYS-1:0]       valid_vec;
    logic [WAY_W-1:0]      vic_way;
    logic                  vic_ptr;
    logic                  adv;
    cache_line_t           vic_line;

    assign idx  = cpu_data_addr[INDEX_BITS-1:0];
    assign tag  = cpu_data_addr[ADDR_W-1:INDEX_BITS];
    assign req  = cpu_read_m | cpu_write_m;
    assign miss = (state == IDLE) && req && !hit;
    assign adv  = (state == FILL_WAIT) && vic_ptr_q;

    // The CPU holds its address during a miss, so idx still selects the victim set.
    assign vic_line = lines[idx][vic_way_q];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        valid_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid_vec[w] = lines[idx][w].valid;
            if (lines[idx][w].valid && lines[idx][w].tag == tag && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    cache_victim_sel #(
        .INDEX_BITS(INDEX_BITS),
        .WAYS      (WAYS),
        .WAY_W     (WAY_W)
    ) u_victim (
        .clk       (clk),
        .reset     (reset),
        .set_idx   (idx),
        .valid_vec (valid_vec),
        .advance   (adv),
        .victim_way(vic_way),
        .by_ptr    (vic_ptr)
    );

`ifdef CACHE_FLUSH_EN
    localparam int WAY_B = $clog2(WAYS);

    logic [INDEX_BITS+WAY_B-1:0] scan_cnt;
    logic [INDEX_BITS-1:0]       scan_set;
    logic [WAY_W-1:0]            scan_way;
    logic                        any_dirty;
    logic                        flush_go;
    cache_line_t                 scan_line;

    assign scan_set = scan_cnt[INDEX_BITS+WAY_B-1:WAY_B];

    generate
        if (WAY_B == 0) begin : g_one_way
            assign scan_way = '0;
        end else begin : g_multi_way
            assign scan_way = scan_cnt[WAY_B-1:0];
        end
    endgenerate

    assign scan_line = lines[scan_set][scan_way];
    assign flush_go  = (state == IDLE) && flush && !miss;

    always_comb begin
        any_dirty = 1'b0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (lines[s][w].dirty) any_dirty = 1'b1;
            end
        end
    end

    assign flush_done = (state == IDLE) && !flush_go && !any_dirty;
    assign cpu_stall  = (state != IDLE) || miss || flush_go;
`else
    assign cpu_stall  = (state != IDLE) || miss;
`endif

    always_comb begin
        cpu_in_m      = '0;
        ram_write_m   = 1'b0;
        ram_data_addr = '0;
        ram_out_m     = '0;
        unique case (state)
            IDLE: begin
                if (cpu_read_m && !cpu_write_m && hit)
                    cpu_in_m = lines[idx][hit_way].data;
            end
            WB: begin
                ram_write_m   = 1'b1;
                ram_data_addr = {vic_line.tag, idx};
                ram_out_m     = vic_line.data;
            end
            FILL_REQ, FILL_WAIT: begin
                ram_data_addr = cpu_data_addr;
            end
`ifdef CACHE_FLUSH_EN
            FLUSH_SCAN: begin
                if (scan_line.dirty) begin
                    ram_write_m   = 1'b1;
                    ram_data_addr = {scan_line.tag, scan_set};
                    ram_out_m     = scan_line.data;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vic_way_q <= '0;
            vic_ptr_q <= 1'b0;
`ifdef CACHE_FLUSH_EN
            scan_cnt  <= '0;
`endif
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) lines[s][w] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        vic_way_q <= vic_way;
                        vic_ptr_q <= vic_ptr;
                        if (lines[idx][vic_way].valid && lines[idx][vic_way].dirty)
                            state <= WB;
                        else
                            state <= FILL_REQ;
`ifdef CACHE_FLUSH_EN
                    end else if (flush_go) begin
                        scan_cnt <= '0;
                        state    <= FLUSH_SCAN;
`endif
                    end else if (cpu_write_m && hit) begin
                        lines[idx][hit_way].data  <= cpu_out_m;
                        lines[idx][hit_way].dirty <= 1'b1;
                    end
                end
                WB:       state <= FILL_REQ;
                FILL_REQ: state <= FILL_WAIT;
                FILL_WAIT: begin
                    // A write miss installs the CPU word directly; the fill data is dropped.
                    lines[idx][vic_way_q] <= '{
                        valid: 1'b1,
                        dirty: cpu_write_m,
                        tag:   tag,
                        data:  cpu_write_m ? cpu_out_m : ram_in_m
                    };
                    state <= IDLE;
                end
`ifdef CACHE_FLUSH_EN
                FLUSH_SCAN: begin
                    if (scan_line.dirty)
                        lines[scan_set][scan_way].dirty <= 1'b0;
                    if (&scan_cnt) state <= IDLE;
                    scan_cnt <= scan_cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
